// File: rtl/bsg_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_cache_pkg
//  Purpose  : Shared cache types: packet opcodes plus the generic request
//             encodings used by the initiator-side packet encoder.
//  Revision : 1.0  initial release
// ============================================================================
package bsg_cache_pkg;

    localparam int c_OPCODE_WIDTH = 6;

    // Cache packet opcodes
    typedef enum logic [c_OPCODE_WIDTH-1:0] {
        LB        = 6'd0,
        LH        = 6'd1,
        LW        = 6'd2,
        LD        = 6'd3,
        LBU       = 6'd4,
        LHU       = 6'd5,
        LWU       = 6'd6,
        LDU       = 6'd7,
        SB        = 6'd8,
        SH        = 6'd9,
        SW        = 6'd10,
        SD        = 6'd11,
        LM        = 6'd12,
        SM        = 6'd13,
        TAGST     = 6'd16,
        TAGFL     = 6'd17,
        TAGLV     = 6'd18,
        TAGLA     = 6'd19,
        AFL       = 6'd24,
        AFLINV    = 6'd25,
        AINV      = 6'd26,
        ALOCK     = 6'd27,
        AUNLOCK   = 6'd28,
        AMOSWAP_W = 6'd32,
        AMOADD_W  = 6'd33,
        AMOXOR_W  = 6'd34,
        AMOAND_W  = 6'd35,
        AMOOR_W   = 6'd36,
        AMOMIN_W  = 6'd37,
        AMOMAX_W  = 6'd38,
        AMOMINU_W = 6'd39,
        AMOMAXU_W = 6'd40,
        AMOSWAP_D = 6'd48,
        AMOADD_D  = 6'd49,
        AMOXOR_D  = 6'd50,
        AMOAND_D  = 6'd51,
        AMOOR_D   = 6'd52,
        AMOMIN_D  = 6'd53,
        AMOMAX_D  = 6'd54,
        AMOMINU_D = 6'd55,
        AMOMAXU_D = 6'd56
    } bsg_cache_opcode_e;

    // Generic request class presented by the master
    typedef enum logic [1:0] {
        e_enc_load  = 2'd0,
        e_enc_store = 2'd1,
        e_enc_amo   = 2'd2,
        e_enc_maint = 2'd3
    } bsg_cache_enc_cmd_e;

    // Atomic operation selector; codes 9..15 are undefined
    typedef enum logic [3:0] {
        e_enc_amo_swap = 4'd0,
        e_enc_amo_add  = 4'd1,
        e_enc_amo_xor  = 4'd2,
        e_enc_amo_and  = 4'd3,
        e_enc_amo_or   = 4'd4,
        e_enc_amo_min  = 4'd5,
        e_enc_amo_max  = 4'd6,
        e_enc_amo_minu = 4'd7,
        e_enc_amo_maxu = 4'd8
    } bsg_cache_enc_amo_e;

    // Maintenance operation selector; codes 9..15 are undefined
    typedef enum logic [3:0] {
        e_enc_tagst   = 4'd0,
        e_enc_tagfl   = 4'd1,
        e_enc_taglv   = 4'd2,
        e_enc_tagla   = 4'd3,
        e_enc_afl     = 4'd4,
        e_enc_aflinv  = 4'd5,
        e_enc_ainv    = 4'd6,
        e_enc_alock   = 4'd7,
        e_enc_aunlock = 4'd8
    } bsg_cache_enc_maint_e;

endpackage
`default_nettype wire

// File: rtl/bsg_counter_up_down.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_counter_up_down
//  Purpose  : Up/down counter; simultaneous up and down leave it unchanged.
//             Callers are responsible for not stepping past 0 or MAX_VAL.
//  Revision : 1.0  initial release
// ============================================================================
module bsg_counter_up_down #(
    parameter  int MAX_VAL   = 4,
    localparam int CNT_WIDTH = $clog2(MAX_VAL + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_up,
    input  logic                 i_down,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam logic [CNT_WIDTH-1:0] c_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count;

    assign o_count = r_count;

    // Net step of +1, -1 or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({i_up, i_down})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_two_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_two_fifo
//  Purpose  : Two-entry valid/ready FIFO. Accepts only when not full, so a
//             full buffer holds its head stable until it is consumed.
//  Revision : 1.0  initial release
// ============================================================================
module bsg_two_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_v,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_v,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_yumi
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_enq;
    logic             w_deq;

    assign o_ready = (r_count != 2'd2);
    assign o_v     = (r_count != 2'd0);
    assign o_data  = r_mem[r_rptr];
    assign w_enq   = i_v & o_ready;
    assign w_deq   = i_yumi & o_v;

    // Pointer and occupancy tracking; cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) r_wptr <= ~r_wptr;
            if (w_deq) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    // Payload storage needs no reset: it is only observed while o_v is high
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/bsg_cache_pkt_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_cache_pkt_encoder
//  Purpose  : Encodes generic memory requests into cache packets, buffers
//             them in a two-entry FIFO and limits issue by outstanding count.
//  Revision : 1.0  initial release
// ============================================================================
module bsg_cache_pkt_encoder
    import bsg_cache_pkg::*;
#(
    parameter  int addr_width_p      = 32,
    parameter  int data_width_p      = 64,
    parameter  int max_outstanding_p = 4,
    localparam int c_MASK_WIDTH      = data_width_p / 8,
    localparam int c_PKT_WIDTH       = c_OPCODE_WIDTH + addr_width_p + data_width_p + c_MASK_WIDTH,
    localparam int c_CREDIT_WIDTH    = $clog2(max_outstanding_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    output logic                      ready_o,
    input  logic [1:0]                cmd_i,
    input  logic [1:0]                size_i,
    input  logic                      unsigned_i,
    input  logic                      mask_en_i,
    input  logic [3:0]                amo_op_i,
    input  logic [3:0]                maint_op_i,
    input  logic [addr_width_p-1:0]   addr_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [c_MASK_WIDTH-1:0]   mask_i,
    output logic [c_PKT_WIDTH-1:0]    cache_pkt_o,
    output logic                      v_o,
    input  logic                      ready_i,
    input  logic                      resp_yumi_i,
    output logic                      error_o,
    output logic [c_CREDIT_WIDTH-1:0] credits_o
);

    typedef struct packed {
        bsg_cache_opcode_e          opcode;
        logic [addr_width_p-1:0]    addr;
        logic [data_width_p-1:0]    data;
        logic [c_MASK_WIDTH-1:0]    mask;
    } bsg_cache_pkt_s;

    localparam logic [c_CREDIT_WIDTH-1:0] c_MAX_CREDITS = c_CREDIT_WIDTH'(max_outstanding_p);
    // Double-word accesses cannot be expressed on a 32-bit data path
    localparam logic c_NO_DOUBLE = (data_width_p == 32);

    bsg_cache_enc_cmd_e   w_cmd;
    bsg_cache_enc_amo_e   w_amo;
    bsg_cache_enc_maint_e w_maint;
    bsg_cache_opcode_e    w_opcode;
    logic                 w_illegal;
    bsg_cache_pkt_s       w_pkt;
    logic                 w_fifo_ready;
    logic                 w_accept;
    logic                 w_enq;
    logic                 w_deq;
    logic                 w_credit_down;
    logic                 r_error;

    assign w_cmd   = bsg_cache_enc_cmd_e'(cmd_i);
    assign w_amo   = bsg_cache_enc_amo_e'(amo_op_i);
    assign w_maint = bsg_cache_enc_maint_e'(maint_op_i);

    // Request to opcode translation with illegal-combination detection
    always_comb begin
        w_opcode  = LB;
        w_illegal = 1'b0;
        case (w_cmd)
            e_enc_load: begin
                if (mask_en_i) begin
                    w_opcode = LM;
                end else begin
                    case (size_i)
                        2'b00:   w_opcode = unsigned_i ? LBU : LB;
                        2'b01:   w_opcode = unsigned_i ? LHU : LH;
                        2'b10:   w_opcode = unsigned_i ? LWU : LW;
                        default: begin
                            w_opcode  = unsigned_i ? LDU : LD;
                            w_illegal = c_NO_DOUBLE;
                        end
                    endcase
                end
            end
            e_enc_store: begin
                if (mask_en_i) begin
                    w_opcode = SM;
                end else begin
                    case (size_i)
                        2'b00:   w_opcode = SB;
                        2'b01:   w_opcode = SH;
                        2'b10:   w_opcode = SW;
                        default: begin
                            w_opcode  = SD;
                            w_illegal = c_NO_DOUBLE;
                        end
                    endcase
                end
            end
            e_enc_amo: begin
                // Only word and double atomics exist
                if (!size_i[1] || (size_i[0] && c_NO_DOUBLE)) w_illegal = 1'b1;
                case (w_amo)
                    e_enc_amo_swap: w_opcode = size_i[0] ? AMOSWAP_D : AMOSWAP_W;
                    e_enc_amo_add:  w_opcode = size_i[0] ? AMOADD_D  : AMOADD_W;
                    e_enc_amo_xor:  w_opcode = size_i[0] ? AMOXOR_D  : AMOXOR_W;
                    e_enc_amo_and:  w_opcode = size_i[0] ? AMOAND_D  : AMOAND_W;
                    e_enc_amo_or:   w_opcode = size_i[0] ? AMOOR_D   : AMOOR_W;
                    e_enc_amo_min:  w_opcode = size_i[0] ? AMOMIN_D  : AMOMIN_W;
                    e_enc_amo_max:  w_opcode = size_i[0] ? AMOMAX_D  : AMOMAX_W;
                    e_enc_amo_minu: w_opcode = size_i[0] ? AMOMINU_D : AMOMINU_W;
                    e_enc_amo_maxu: w_opcode = size_i[0] ? AMOMAXU_D : AMOMAXU_W;
                    default:        w_illegal = 1'b1;
                endcase
            end
            e_enc_maint: begin
                case (w_maint)
                    e_enc_tagst:   w_opcode = TAGST;
                    e_enc_tagfl:   w_opcode = TAGFL;
                    e_enc_taglv:   w_opcode = TAGLV;
                    e_enc_tagla:   w_opcode = TAGLA;
                    e_enc_afl:     w_opcode = AFL;
                    e_enc_aflinv:  w_opcode = AFLINV;
                    e_enc_ainv:    w_opcode = AINV;
                    e_enc_alock:   w_opcode = ALOCK;
                    e_enc_aunlock: w_opcode = AUNLOCK;
                    default:       w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Packet assembly; mask only carries meaning for masked loads/stores
    always_comb begin
        w_pkt.opcode = w_opcode;
        w_pkt.addr   = addr_i;
        w_pkt.data   = data_i;
        w_pkt.mask   = mask_en_i ? mask_i : '0;
    end

    // Illegal requests pass through the same gate so they cannot bypass a
    // stalled buffer or credit limit
    assign ready_o       = w_fifo_ready & (credits_o < c_MAX_CREDITS);
    assign w_accept      = v_i & ready_o;
    assign w_enq         = w_accept & ~w_illegal;
    assign w_deq         = v_o & ready_i;
    assign w_credit_down = resp_yumi_i & (credits_o != '0);

    bsg_two_fifo #(
        .WIDTH (c_PKT_WIDTH)
    ) u_out_fifo (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_v     (w_enq),
        .i_data  (w_pkt),
        .o_ready (w_fifo_ready),
        .o_v     (v_o),
        .o_data  (cache_pkt_o),
        .i_yumi  (w_deq)
    );

    bsg_counter_up_down #(
        .MAX_VAL (max_outstanding_p)
    ) u_credits (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_up    (w_enq),
        .i_down  (w_credit_down),
        .o_count (credits_o)
    );

    // One-cycle pulse reporting a dropped illegal request
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_error <= 1'b0;
        else         r_error <= w_accept & w_illegal;
    end

    assign error_o = r_error;

    // A response with nothing outstanding indicates a broken master
    a_no_credit_underflow: assert property (
        @(posedge clk_i) disable iff (reset_i) !(resp_yumi_i && (credits_o == '0))
    );

endmodule
`default_nettype wire

// File: tb/tb_bsg_cache_pkt_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_cache_pkt_encoder
//  Purpose  : Randomized scoreboard bench for bsg_cache_pkt_encoder
//  Revision : 1.0  initial release
// ============================================================================
module tb_bsg_cache_pkt_encoder;

    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int MW   = DW / 8;
    localparam int MAXO = 4;
    localparam int PW   = 6 + AW + DW + MW;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic          ready_o;
    logic [1:0]    cmd_i = '0;
    logic [1:0]    size_i = '0;
    logic          unsigned_i = 1'b0;
    logic          mask_en_i = 1'b0;
    logic [3:0]    amo_op_i = '0;
    logic [3:0]    maint_op_i = '0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] data_i = '0;
    logic [MW-1:0] mask_i = '0;
    logic [PW-1:0] cache_pkt_o;
    logic          v_o;
    logic          ready_i = 1'b0;
    logic          resp_yumi_i = 1'b0;
    logic          error_o;
    logic [CW-1:0] credits_o;

    bsg_cache_pkt_encoder #(
        .addr_width_p      (AW),
        .data_width_p      (DW),
        .max_outstanding_p (MAXO)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .cmd_i       (cmd_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .mask_en_i   (mask_en_i),
        .amo_op_i    (amo_op_i),
        .maint_op_i  (maint_op_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .mask_i      (mask_i),
        .cache_pkt_o (cache_pkt_o),
        .v_o         (v_o),
        .ready_i     (ready_i),
        .resp_yumi_i (resp_yumi_i),
        .error_o     (error_o),
        .credits_o   (credits_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural state: packets in the buffer, outstanding count, error due
    logic [PW-1:0] sb [$];
    int            m_occ = 0;
    int            m_cnt = 0;
    bit            m_err = 1'b0;

    int maint_code [9] = '{16, 17, 18, 19, 24, 25, 26, 27, 28};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Opcode numbering: loads 0..7 (unsigned +4), stores 8..11, LM 12,
    // SM 13, maint table, word atomics 32+op, double atomics 48+op
    function automatic bit ref_enc(input logic [1:0] c, input logic [1:0] s, input logic u,
                                   input logic me, input logic [3:0] ao, input logic [3:0] mo,
                                   output logic [5:0] op);
        op = 6'd0;
        case (c)
            2'd0: begin
                if (me) begin op = 6'd12; return 1'b1; end
                if (DW == 32 && s == 2'd3) return 1'b0;
                op = 6'(int'(s) + (u ? 4 : 0));
                return 1'b1;
            end
            2'd1: begin
                if (me) begin op = 6'd13; return 1'b1; end
                if (DW == 32 && s == 2'd3) return 1'b0;
                op = 6'(8 + int'(s));
                return 1'b1;
            end
            2'd2: begin
                if (s < 2'd2 || ao > 4'd8 || (DW == 32 && s == 2'd3)) return 1'b0;
                op = 6'(((s == 2'd3) ? 48 : 32) + int'(ao));
                return 1'b1;
            end
            default: begin
                if (mo > 4'd8) return 1'b0;
                op = 6'(maint_code[mo]);
                return 1'b1;
            end
        endcase
    endfunction

    task automatic set_req(input logic [1:0] c, input logic [1:0] s, input logic u, input logic me,
                           input logic [3:0] ao, input logic [3:0] mo, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m);
        v_i = 1'b1; cmd_i = c; size_i = s; unsigned_i = u; mask_en_i = me;
        amo_op_i = ao; maint_op_i = mo; addr_i = a; data_i = d; mask_i = m;
    endtask

    task automatic set_rand_req();
        set_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom),
                ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)),
                $urandom, {$urandom, $urandom}, 8'($urandom));
    endtask

    // One cycle: inputs were driven at the preceding negedge
    task automatic tick(output bit acc);
        logic [5:0] op;
        bit         legal;
        bit         enq;
        bit         deliver;
        bit         exp_ready;
        #1;
        exp_ready = (m_occ < 2) && (m_cnt < MAXO);
        chk("credits_o", credits_o, m_cnt);
        chk("ready_o", ready_o, exp_ready);
        chk("v_o", v_o, (m_occ != 0));
        chk("error_o", error_o, m_err);
        legal = ref_enc(cmd_i, size_i, unsigned_i, mask_en_i, amo_op_i, maint_op_i, op);
        acc   = v_i && exp_ready;
        enq   = acc && legal;
        if (enq) sb.push_back({op, addr_i, data_i, (mask_en_i ? mask_i : {MW{1'b0}})});
        m_err   = acc && !legal;
        deliver = (m_occ != 0) && ready_i;
        m_occ   = m_occ + int'(enq) - int'(deliver);
        m_cnt   = m_cnt + int'(enq) - int'(resp_yumi_i && (m_cnt != 0));
        @(negedge clk);
    endtask

    // Called right after a negedge; reset takes effect immediately
    task automatic do_reset();
        reset_i = 1'b1; v_i = 1'b0; resp_yumi_i = 1'b0;
        sb.delete();
        #1;
        chk("reset_v_o", v_o, 1'b0);
        chk("reset_credits", credits_o, '0);
        chk("reset_error", error_o, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        m_occ = 0; m_cnt = 0; m_err = 1'b0;
    endtask

    // Scoreboard monitor: pops one expectation per handshake on the cache side
    initial begin
        logic [PW-1:0] exp_pkt;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_i && v_o && ready_i) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pkt_unexpected: got %0h expected none", cache_pkt_o);
                end else begin
                    exp_pkt = sb.pop_front();
                    chk("pkt", cache_pkt_o, exp_pkt);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit got;
        @(negedge clk);
        do_reset();

        // Single legal and illegal requests
        ready_i = 1'b1;
        set_req(2'd0, 2'd2, 1'b1, 1'b0, 4'd0, 4'd0, 32'h100, '0, '0);     // LWU
        tick(acc); v_i = 1'b0; tick(acc);
        set_req(2'd1, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 32'h200, 64'hDEADBEEF, 8'h0F); // SM
        tick(acc); v_i = 1'b0; tick(acc);
        set_req(2'd2, 2'd1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h300, 64'h1, '0);  // illegal AMO
        tick(acc); v_i = 1'b0; tick(acc);
        set_req(2'd2, 2'd3, 1'b0, 1'b0, 4'd6, 4'd0, 32'h308, 64'h55, '0); // AMOMAX_D
        tick(acc); v_i = 1'b0; tick(acc);
        set_req(2'd3, 2'd0, 1'b0, 1'b0, 4'd0, 4'd12, 32'h400, '0, '0);    // illegal maint
        tick(acc); v_i = 1'b0; tick(acc);

        // Buffer full with cache stalled
        do_reset();
        ready_i = 1'b0;
        set_req(2'd0, 2'd0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h10, '0, '0); tick(acc);
        set_req(2'd0, 2'd1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h12, '0, '0); tick(acc);
        set_req(2'd0, 2'd2, 1'b0, 1'b0, 4'd0, 4'd0, 32'h14, '0, '0); tick(acc);
        chk("full_ready_o", ready_o, 1'b0);
        ready_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            tick(acc);
            got = acc;
        end
        v_i = 1'b0; tick(acc); tick(acc); tick(acc);

        // Credit limit, response returning a credit, mid-stream reset
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < MAXO; i++) begin
            set_req(2'd0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 4'd0, 4'd0, $urandom, '0, '0);
            tick(acc);
        end
        set_req(2'd1, 2'd2, 1'b0, 1'b0, 4'd0, 4'd0, 32'h500, 64'h77, '0);
        chk("credit_limit_ready_o", ready_o, 1'b0);
        resp_yumi_i = 1'b1; tick(acc);
        resp_yumi_i = 1'b0; tick(acc);
        ready_i = 1'b0; tick(acc); tick(acc);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 9) < 7) set_rand_req();
            else v_i = 1'b0;
            ready_i     = ($urandom_range(0, 3) != 0);
            resp_yumi_i = (m_cnt > 0) && ($urandom_range(0, 9) < 4);
            tick(acc);
        end

        // Drain
        v_i = 1'b0;
        ready_i = 1'b1;
        for (int n = 0; n < 12; n++) begin
            resp_yumi_i = (m_cnt > 0);
            tick(acc);
        end
        resp_yumi_i = 1'b0;
        tick(acc);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
